toggle_monitor: RTL
===================

Name: toggle_monitor

Overview:
- Downstream consumer of the single-bit `hello` output (B).
- Debounces the bit and emits one-cycle rise/fall pulses on each accepted transition.
- Keeps saturating counts of rising and falling transitions, with a sticky overflow flag.
- Benches and later stages use it to check toggle activity without relying on `$monitor` text.

Parameters:
- STABLE_CYCLES, 4, consecutive sampled cycles a new level must hold before it is accepted (legal range 2..255).
- CNT_W, 8, width of each transition counter.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- sig_in  input  1  monitored bit (driven by hello B)
- clear  input  1  synchronous clear of counters and overflow
- sig_stable  output  1  debounced level
- rise_pulse  output  1  one-cycle pulse on accepted 0->1
- fall_pulse  output  1  one-cycle pulse on accepted 1->0
- rise_count  output  CNT_W  accepted rising transitions, saturating
- fall_count  output  CNT_W  accepted falling transitions, saturating
- overflow  output  1  sticky; set when either counter is incremented while at max

Behaviour:
- Reset (rst=1 at an edge):
  - s_q=0, FSM=STABLE_LO, dbc=0.
  - sig_stable=0, rise_pulse=0, fall_pulse=0, rise_count=0, fall_count=0, overflow=0.
  - rst overrides clear and all events.
- Input stage: sig_in is registered into s_q on every edge. The FSM acts only on s_q.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Debounce counter dbc is 8 bits.
  - STABLE_LO: if s_q=1, go to WAIT_HI with dbc=1; otherwise stay.
  - WAIT_HI: if s_q=0, go to STABLE_LO (glitch rejected, no pulse). Else if dbc==STABLE_CYCLES-1, go to STABLE_HI and set rise_pulse=1 for one cycle. Else dbc++.
  - STABLE_HI and WAIT_LO mirror the above with polarity inverted; the accepted transition sets fall_pulse.
- sig_stable is 1 in STABLE_HI and WAIT_LO, and 0 otherwise.
- Latency:
  - If sig_in is high at edges k..k+STABLE_CYCLES-1, then sig_stable=1 and rise_pulse=1 after edge k+STABLE_CYCLES.
  - A run shorter than STABLE_CYCLES produces no pulse and no count change.
- Pulses:
  - Registered, one cycle wide.
  - rise_pulse and fall_pulse are never high together.
  - At least STABLE_CYCLES cycles separate consecutive pulses.
- Counters:
  - A counter increments on the same edge its pulse is asserted, so the new count is visible in the pulse cycle.
  - At 2^CNT_W-1 the counter holds its value and overflow is set. overflow clears only on rst or clear.
- clear:
  - Next edge: rise_count=0, fall_count=0, overflow=0.
  - clear does not affect the FSM, sig_stable or the pulses.
  - If clear coincides with an accepted transition, the pulse is still emitted, the count becomes 0 (clear wins), and overflow=0.
- Reset mid-operation (rst during WAIT_HI or STABLE_HI): return to STABLE_LO. If sig_in stays high, a fresh rise is accepted STABLE_CYCLES+1 edges after rst deasserts, and rise_count reads 1.
- No X propagation: all outputs are defined from the first post-reset cycle.

Decomposition:
- Package toggle_monitor_pkg holds:
  - FSM state encoding (2-bit localparams ST_STABLE_LO=0, ST_WAIT_HI=1, ST_STABLE_HI=2, ST_WAIT_LO=3).
  - Default STABLE_CYCLES and CNT_W values.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, count, ovf) is instantiated twice, for rise and fall.
  - overflow = OR of the two ovf outputs, each sticky.
- Debounce FSM, input register and pulse registers are inline in toggle_monitor.

Test Plan:
- Reset, then sig_in=0 for 20 cycles -> sig_stable=0, no pulses, both counts 0, overflow=0.
- sig_in 0->1 held, rising at edge 10 (STABLE_CYCLES=4) -> rise_pulse high only after edge 14, sig_stable=1 from then, rise_count=1.
- Glitch of sig_in=1 for 3 cycles, then 0 -> no pulse, sig_stable stays 0, rise_count=0. Repeat with a 4-cycle high -> exactly one rise, then one fall, counts 1/1.
- CNT_W=3, 9 full high/low toggles -> rise_count=7 and fall_count=7 (saturated), overflow=1. Then clear=1 for one cycle -> counts 0 and overflow=0 on the next cycle.
- clear asserted in the same cycle as the FSM's 4th qualifying sample -> rise_pulse=1 in that cycle, rise_count=0 afterwards.
- rst pulsed for 1 cycle while in STABLE_HI with sig_in held 1 -> sig_stable=0 and counts 0 immediately after. Fresh rise_pulse after 5 edges post-deassert, rise_count=1.

Source files
------------

// File: rtl/toggle_monitor_pkg.sv
// Shared definitions for the toggle monitor: debounce FSM encoding and
// default parameter values.
package toggle_monitor_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky overflow flag; holds at all-ones
// and raises ovf on any further increment until rst or clr.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         ovf
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (count == {W{1'b1}}) begin
                ovf <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/toggle_monitor.sv
// Debounces a single-bit input, emits one-cycle rise/fall pulses on accepted
// transitions and keeps saturating transition counts with a sticky overflow.
module toggle_monitor
    import toggle_monitor_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clear,
    output logic             sig_stable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] fall_count,
    output logic             overflow
);

    localparam logic [7:0] DBC_LAST = 8'(STABLE_CYCLES - 1);

    logic       s_q;
    state_t     state, state_nx;
    logic [7:0] dbc, dbc_nx;
    logic       rise_acc, fall_acc;
    logic       rise_ovf, fall_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= 1'b0;
            state      <= ST_STABLE_LO;
            dbc        <= 8'd0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s_q        <= sig_in;
            state      <= state_nx;
            dbc        <= dbc_nx;
            rise_pulse <= rise_acc;
            fall_pulse <= fall_acc;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        dbc_nx   = dbc;
        rise_acc = 1'b0;
        fall_acc = 1'b0;
        unique case (state)
            ST_STABLE_LO: begin
                if (s_q) begin
                    state_nx = ST_WAIT_HI;
                    dbc_nx   = 8'd1;
                end
            end
            ST_WAIT_HI: begin
                if (!s_q) begin
                    state_nx = ST_STABLE_LO;
                end else if (dbc == DBC_LAST) begin
                    state_nx = ST_STABLE_HI;
                    rise_acc = 1'b1;
                end else begin
                    dbc_nx = dbc + 8'd1;
                end
            end
            ST_STABLE_HI: begin
                if (!s_q) begin
                    state_nx = ST_WAIT_LO;
                    dbc_nx   = 8'd1;
                end
            end
            ST_WAIT_LO: begin
                if (s_q) begin
                    state_nx = ST_STABLE_HI;
                end else if (dbc == DBC_LAST) begin
                    state_nx = ST_STABLE_LO;
                    fall_acc = 1'b1;
                end else begin
                    dbc_nx = dbc + 8'd1;
                end
            end
            default: state_nx = ST_STABLE_LO;
        endcase
    end

    assign sig_stable = (state == ST_STABLE_HI) || (state == ST_WAIT_LO);

    // Counters take the combinational accept so the new count lands with the pulse.
    sat_counter #(.W(CNT_W)) u_rise_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (rise_acc),
        .count (rise_count),
        .ovf   (rise_ovf)
    );

    sat_counter #(.W(CNT_W)) u_fall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (fall_acc),
        .count (fall_count),
        .ovf   (fall_ovf)
    );

    assign overflow = rise_ovf | fall_ovf;

endmodule
